// File: rtl/id_stage_sb.sv
// id_stage_sb: instruction-decode stage between IF and EX.
// Decodes the 7-bit opcode, reads rd/rs from an internal N_REG x W_DATA register
// file and tracks outstanding destination writes with a per-register busy bit.
// Valid/ready handshakes on both sides; flush_i kills the input and the output register.
// Optional feature macro: ID_WB_BYPASS_EN -- forwards a same-cycle write-back into
// the hazard check and the operand read so a dependent instruction issues without
// waiting for the register-file update.
module id_stage_sb #(
  parameter int W_DATA = 32,
  parameter int W_PC   = 16,
  parameter int N_REG  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       inst_i,
  input  logic              inst_valid_i,
  output logic              inst_ready_o,
  input  logic [W_PC-1:0]   pc_value_i,
  input  logic              flush_i,
  input  logic              wb_i,
  input  logic [3:0]        wb_r_i,
  input  logic [W_DATA-1:0] wb_data_i,
  input  logic              ex_ready_i,
  output logic              ex_valid_o,
  output logic [5:0]        ctrl_o,
  output logic              immf_o,
  output logic [W_DATA-1:0] imm_value_o,
  output logic [W_DATA-1:0] rd_value_o,
  output logic [W_DATA-1:0] rs_value_o,
  output logic [W_PC-1:0]   pc_value_o,
  output logic [6:0]        opcode_o,
  output logic [3:0]        rd_addr_o,
  output logic              rsv_o,
  output logic              und_o
);

  localparam int         W_ADDR  = (N_REG > 1) ? $clog2(N_REG) : 1;
  localparam logic [4:0] N_REG_L = 5'(N_REG);
  localparam logic [6:0] OPC_NOP = 7'b0011110;

  // ctrl bit positions: {inte, logic, shift, ld, st, br}
  localparam int C_INTE  = 5;
  localparam int C_LOGIC = 4;
  localparam int C_SHIFT = 3;
  localparam int C_LD    = 2;
  localparam int C_ST    = 1;
  localparam int C_BR    = 0;

  typedef struct packed {
    logic              valid;
    logic [5:0]        ctrl;
    logic              immf;
    logic [W_DATA-1:0] imm;
    logic [W_DATA-1:0] rd_val;
    logic [W_DATA-1:0] rs_val;
    logic [W_PC-1:0]   pc;
    logic [6:0]        opc;
    logic [3:0]        rd;
    logic              rsv;
    logic              und;
  } issue_t;

  function automatic issue_t bubble();
    issue_t b;
    b     = '0;
    b.opc = OPC_NOP;
    return b;
  endfunction

  // Addresses at or above N_REG read as zero, are never busy and are never written.
  function automatic logic in_range(input logic [3:0] a);
    return {1'b0, a} < N_REG_L;
  endfunction

  // Instruction fields
  logic [6:0]  opc;
  logic        immf;
  logic [3:0]  rd_f;
  logic [3:0]  rs_f;
  logic [15:0] imm_f;
  assign opc   = inst_i[31:25];
  assign immf  = inst_i[24];
  assign rd_f  = inst_i[23:20];
  assign rs_f  = inst_i[19:16];
  assign imm_f = inst_i[15:0];

  logic              rd_ok, rs_ok, wb_ok;
  logic [W_ADDR-1:0] rd_idx, rs_idx, wb_idx;
  assign rd_ok  = in_range(rd_f);
  assign rs_ok  = in_range(rs_f);
  assign wb_ok  = wb_i & in_range(wb_r_i);
  assign rd_idx = rd_f[W_ADDR-1:0];
  assign rs_idx = rs_f[W_ADDR-1:0];
  assign wb_idx = wb_r_i[W_ADDR-1:0];

  logic [W_DATA-1:0] regfile [N_REG];
  logic [N_REG-1:0]  busy;
  issue_t            out_q;
  issue_t            issue_d;

  logic [5:0]        d_ctrl;
  logic              d_defined, d_rsv, d_und, d_uses;
  logic [W_DATA-1:0] d_imm;

  // Opcode decode into class bits, reservation and immediate extension.
  // NOTE: every signal written here gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    d_ctrl    = '0;
    d_defined = 1'b1;
    casez (opc)
      7'b0000???:                                      d_ctrl[C_INTE]  = 1'b1;
      7'b0001000, 7'b0001001, 7'b0001010,
      7'b0001100, 7'b0001101:                          d_ctrl[C_SHIFT] = 1'b1;
      7'b00100??:                                      d_ctrl[C_LOGIC] = 1'b1;
      7'b001011?:                                      d_ctrl          = '0;  // set class
      7'b0011000:                                      d_ctrl[C_LD]    = 1'b1;
      7'b0011001:                                      d_ctrl[C_ST]    = 1'b1;
      7'b001110?:                                      d_ctrl[C_BR]    = 1'b1;
      7'b001111?:                                      d_ctrl          = '0;  // nop-type
      default:                                         d_defined       = 1'b0;
    endcase
    d_rsv  = d_defined & (opc != 7'b0000100) & (opc[6:2] != 5'b00111);
    d_und  = ~d_defined;
    d_uses = d_ctrl[C_INTE] | d_ctrl[C_LOGIC] | d_ctrl[C_SHIFT] |
             d_ctrl[C_LD] | d_ctrl[C_ST] | d_rsv;
    if (d_ctrl[C_SHIFT]) d_imm = {{(W_DATA-16){1'b0}}, imm_f};
    else                 d_imm = {{(W_DATA-16){imm_f[15]}}, imm_f};
  end

  logic              busy_rd, busy_rs, hazard, accept;
  logic [W_DATA-1:0] rd_val, rs_val;

  // Operand read and hazard detection, optionally bypassing the current write-back.
  always_comb begin
    busy_rd = rd_ok & busy[rd_idx];
    busy_rs = rs_ok & busy[rs_idx];
    rd_val  = rd_ok ? regfile[rd_idx] : '0;
    rs_val  = rs_ok ? regfile[rs_idx] : '0;
`ifdef ID_WB_BYPASS_EN
    if (wb_ok && (wb_r_i == rd_f)) begin
      busy_rd = 1'b0;
      rd_val  = wb_data_i;
    end
    if (wb_ok && (wb_r_i == rs_f)) begin
      busy_rs = 1'b0;
      rs_val  = wb_data_i;
    end
`endif
    hazard = d_uses & (busy_rd | (~immf & busy_rs));
  end

  assign inst_ready_o = (~hazard & (~out_q.valid | ex_ready_i)) | flush_i;
  assign accept       = inst_valid_i & inst_ready_o & ~flush_i;

  // Assemble the would-be output register contents for an accepted instruction.
  always_comb begin
    issue_d        = bubble();
    issue_d.valid  = 1'b1;
    issue_d.ctrl   = d_ctrl;
    issue_d.immf   = immf;
    issue_d.imm    = d_imm;
    issue_d.rd_val = rd_val;
    issue_d.rs_val = rs_val;
    issue_d.pc     = pc_value_i;
    issue_d.opc    = opc;
    issue_d.rd     = rd_f;
    issue_d.rsv    = d_rsv;
    issue_d.und    = d_und;
  end

  // Output register: flush > accept > consume-to-bubble > hold.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                  out_q <= bubble();
    else if (flush_i)          out_q <= bubble();
    else if (accept)           out_q <= issue_d;
    else if (ex_ready_i)       out_q <= bubble();
  end

  // Scoreboard: write-back clears, an accepted reserving instruction sets (set wins).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy <= '0;
    end else begin
      if (wb_ok)                    busy[wb_idx] <= 1'b0;
      if (accept && d_rsv && rd_ok) busy[rd_idx] <= 1'b1;
    end
  end

  // Register file write port.
  // NOTE: this storage is architecturally required to clear on reset, so it is built from resettable flops rather than RAM.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N_REG; i++) regfile[i] <= '0;
    end else if (wb_ok) begin
      regfile[wb_idx] <= wb_data_i;
    end
  end

  assign ex_valid_o  = out_q.valid;
  assign ctrl_o      = out_q.ctrl;
  assign immf_o      = out_q.immf;
  assign imm_value_o = out_q.imm;
  assign rd_value_o  = out_q.rd_val;
  assign rs_value_o  = out_q.rs_val;
  assign pc_value_o  = out_q.pc;
  assign opcode_o    = out_q.opc;
  assign rd_addr_o   = out_q.rd;
  assign rsv_o       = out_q.rsv;
  assign und_o       = out_q.und;

endmodule

// File: tb/tb_id_stage_sb.sv
// tb_id_stage_sb: directed self-checking bench for id_stage_sb (default parameters).
module tb_id_stage_sb;

  localparam int W_DATA = 32;
  localparam int W_PC   = 16;
  localparam int N_REG  = 16;
  localparam logic [6:0] NOP = 7'b0011110;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [31:0]       inst_i = '0;
  logic              inst_valid_i = 1'b0;
  logic              inst_ready_o;
  logic [W_PC-1:0]   pc_value_i = '0;
  logic              flush_i = 1'b0;
  logic              wb_i = 1'b0;
  logic [3:0]        wb_r_i = '0;
  logic [W_DATA-1:0] wb_data_i = '0;
  logic              ex_ready_i = 1'b0;
  logic              ex_valid_o;
  logic [5:0]        ctrl_o;
  logic              immf_o;
  logic [W_DATA-1:0] imm_value_o;
  logic [W_DATA-1:0] rd_value_o;
  logic [W_DATA-1:0] rs_value_o;
  logic [W_PC-1:0]   pc_value_o;
  logic [6:0]        opcode_o;
  logic [3:0]        rd_addr_o;
  logic              rsv_o;
  logic              und_o;

  int checks = 0;
  int errors = 0;

  id_stage_sb #(.W_DATA(W_DATA), .W_PC(W_PC), .N_REG(N_REG)) dut (
    .clk(clk), .rst(rst), .inst_i(inst_i), .inst_valid_i(inst_valid_i),
    .inst_ready_o(inst_ready_o), .pc_value_i(pc_value_i), .flush_i(flush_i),
    .wb_i(wb_i), .wb_r_i(wb_r_i), .wb_data_i(wb_data_i), .ex_ready_i(ex_ready_i),
    .ex_valid_o(ex_valid_o), .ctrl_o(ctrl_o), .immf_o(immf_o),
    .imm_value_o(imm_value_o), .rd_value_o(rd_value_o), .rs_value_o(rs_value_o),
    .pc_value_o(pc_value_o), .opcode_o(opcode_o), .rd_addr_o(rd_addr_o),
    .rsv_o(rsv_o), .und_o(und_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mk(input logic [6:0] opc, input logic immf,
                                     input logic [3:0] rd, input logic [3:0] rs,
                                     input logic [15:0] imm);
    return {opc, immf, rd, rs, imm};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state
    #12;
    check("rst_valid",  64'(ex_valid_o), 64'd0);
    check("rst_opcode", 64'(opcode_o),   64'(NOP));
    check("rst_ctrl",   64'(ctrl_o),     64'd0);
    check("rst_rsv",    64'(rsv_o),      64'd0);
    check("rst_imm",    64'(imm_value_o), 64'd0);
    check("rst_ready",  64'(inst_ready_o), 64'd1);
    rst = 1'b1;
    tick();

    // Preload r4 = 0x55
    wb_i = 1'b1; wb_r_i = 4'd4; wb_data_i = 32'h55;
    tick();
    wb_i = 1'b0;

    // Immediates: inte sign-extends, shift zero-extends
    ex_ready_i = 1'b1; inst_valid_i = 1'b1;
    inst_i = mk(7'b0000000, 1'b1, 4'd1, 4'd2, 16'h8000); pc_value_i = 16'h0010;
    @(negedge clk);
    check("inte_ready", 64'(inst_ready_o), 64'd1);
    tick();
    check("inte_valid", 64'(ex_valid_o),  64'd1);
    check("inte_ctrl",  64'(ctrl_o),      64'b100000);
    check("inte_imm",   64'(imm_value_o), 64'hFFFF8000);
    check("inte_rsv",   64'(rsv_o),       64'd1);
    check("inte_pc",    64'(pc_value_o),  64'h0010);
    check("inte_rd",    64'(rd_addr_o),   64'd1);
    inst_i = mk(7'b0001000, 1'b1, 4'd2, 4'd4, 16'h8000); pc_value_i = 16'h0014;
    tick();
    check("shift_imm",  64'(imm_value_o), 64'h00008000);
    check("shift_ctrl", 64'(ctrl_o),      64'b001000);
    check("shift_rs",   64'(rs_value_o),  64'h55);
    check("shift_opc",  64'(opcode_o),    64'h08);

    // Undefined opcode issues but never reserves
    inst_i = mk(7'b1111111, 1'b0, 4'd6, 4'd6, 16'h0000);
    tick();
    check("und_valid", 64'(ex_valid_o), 64'd1);
    check("und_und",   64'(und_o),      64'd1);
    check("und_ctrl",  64'(ctrl_o),     64'd0);
    check("und_rsv",   64'(rsv_o),      64'd0);
    check("und_opc",   64'(opcode_o),   64'h7F);
    inst_valid_i = 1'b0;
    inst_i = mk(7'b0000000, 1'b0, 4'd6, 4'd6, 16'h0000);
    @(negedge clk);
    check("und_nobusy_ready", 64'(inst_ready_o), 64'd1);
    tick();
    check("bubble_valid", 64'(ex_valid_o), 64'd0);
    check("bubble_opc",   64'(opcode_o),   64'(NOP));
    check("bubble_und",   64'(und_o),      64'd0);
    check("bubble_pc",    64'(pc_value_o), 64'd0);

    // Reset mid-stream with ld r3 outstanding
    ex_ready_i = 1'b0; inst_valid_i = 1'b1;
    inst_i = mk(7'b0011000, 1'b1, 4'd3, 4'd0, 16'h0000);
    tick();
    check("ld_valid", 64'(ex_valid_o), 64'd1);
    check("ld_ctrl",  64'(ctrl_o),     64'b000100);
    inst_valid_i = 1'b0;
    inst_i = mk(7'b0000000, 1'b0, 4'd5, 4'd3, 16'h0000);
    @(negedge clk);
    check("pre_rst_ready", 64'(inst_ready_o), 64'd0);
    #2 rst = 1'b0;
    #1;
    check("mid_rst_valid", 64'(ex_valid_o),   64'd0);
    check("mid_rst_opc",   64'(opcode_o),     64'(NOP));
    check("mid_rst_ready", 64'(inst_ready_o), 64'd1);
    #1 rst = 1'b1;
    ex_ready_i = 1'b1;
    tick();

    // ld r3 then add r3,r4: stall until write-back of r3
    inst_valid_i = 1'b1;
    inst_i = mk(7'b0011000, 1'b1, 4'd3, 4'd0, 16'h0004); pc_value_i = 16'h0020;
    tick();
    inst_i = mk(7'b0000000, 1'b0, 4'd3, 4'd4, 16'h0000); pc_value_i = 16'h0024;
    @(negedge clk);
    check("raw_stall_ready", 64'(inst_ready_o), 64'd0);
    tick();
    check("raw_stall_valid", 64'(ex_valid_o), 64'd0);
    wb_i = 1'b1; wb_r_i = 4'd3; wb_data_i = 32'h1234;
    @(negedge clk);
`ifdef ID_WB_BYPASS_EN
    check("raw_wb_ready", 64'(inst_ready_o), 64'd1);
    tick();
    wb_i = 1'b0;
`else
    check("raw_wb_ready", 64'(inst_ready_o), 64'd0);
    tick();
    wb_i = 1'b0;
    check("raw_wb_valid", 64'(ex_valid_o), 64'd0);
    @(negedge clk);
    check("raw_post_wb_ready", 64'(inst_ready_o), 64'd1);
    tick();
`endif
    check("raw_valid", 64'(ex_valid_o), 64'd1);
    check("raw_rdval", 64'(rd_value_o), 64'h1234);
    check("raw_rsval", 64'(rs_value_o), 64'd0);
    check("raw_pc",    64'(pc_value_o), 64'h0024);

    // Back-pressure: output held while EX is not ready
    inst_i = mk(7'b0010001, 1'b1, 4'd7, 4'd8, 16'h00FF); pc_value_i = 16'h0040;
    tick();
    check("logic_ctrl", 64'(ctrl_o), 64'b010000);
    ex_ready_i = 1'b0;
    inst_i = mk(7'b0011001, 1'b1, 4'd9, 4'd10, 16'h0002); pc_value_i = 16'h0044;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("bp_ready", 64'(inst_ready_o), 64'd0);
      check("bp_valid", 64'(ex_valid_o),   64'd1);
      check("bp_opc",   64'(opcode_o),     64'h11);
      check("bp_imm",   64'(imm_value_o),  64'h000000FF);
      check("bp_pc",    64'(pc_value_o),   64'h0040);
    end
    ex_ready_i = 1'b1;
    #1;
    check("bp_release_ready", 64'(inst_ready_o), 64'd1);
    tick();
    check("st_valid", 64'(ex_valid_o),  64'd1);
    check("st_opc",   64'(opcode_o),    64'h19);
    check("st_ctrl",  64'(ctrl_o),      64'b000010);
    check("st_imm",   64'(imm_value_o), 64'd2);
    check("st_rsv",   64'(rsv_o),       64'd1);

    // Flush discards ld r5 and leaves existing busy bits alone
    flush_i = 1'b1;
    inst_i = mk(7'b0011000, 1'b1, 4'd5, 4'd0, 16'h0000); pc_value_i = 16'h0050;
    @(negedge clk);
    check("flush_ready", 64'(inst_ready_o), 64'd1);
    tick();
    flush_i = 1'b0; inst_valid_i = 1'b0;
    check("flush_valid", 64'(ex_valid_o), 64'd0);
    check("flush_opc",   64'(opcode_o),   64'(NOP));
    inst_i = mk(7'b0000000, 1'b0, 4'd5, 4'd5, 16'h0000);
    @(negedge clk);
    check("flush_r5_free", 64'(inst_ready_o), 64'd1);
    inst_i = mk(7'b0000000, 1'b0, 4'd6, 4'd3, 16'h0000);
    #1;
    check("flush_r3_kept", 64'(inst_ready_o), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
